// File: rtl/bin2therm_slew.sv
// -----------------------------------------------------------------------------
// bin2therm_slew
//
// Registered binary-to-thermometer converter with slew limiting. This block
// drives the coarse DCO/DAC control in the locking loop. A binary target comes
// in through a valid/ready handshake. The registered thermometer output then
// walks toward that target by at most MAX_STEP codes per clock, so the unit
// cells never switch in large glitching bursts.
//
// Parameters:
//   N_BITS   - binary width; the thermometer output is 2**N_BITS-1 bits wide
//   MAX_STEP - largest change of the level per clock (1 .. 2**N_BITS-1)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   in_valid in   a target is present on 'in'
//   in_ready out  the block can accept a target
//   in       in   binary target code
//   out      out  registered thermometer code; bit i = (i < level)
//   level    out  registered binary equivalent of 'out'
//   busy     out  a slew is in progress
//   done     out  one-cycle pulse when level reaches the accepted target
//
// Optional feature (macro BIN2THERM_RETARGET_EN):
//   When defined, 'in' is also accepted during a slew and replaces the target.
//   The step taken on that edge still heads toward the old target. Later
//   steps head toward the new one, and may reverse direction. When undefined,
//   in_ready is low during a slew and in_valid is ignored.
// -----------------------------------------------------------------------------
module bin2therm_slew #(
  parameter int N_BITS   = 5,
  parameter int MAX_STEP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_BITS-1:0]      in,
  output logic [2**N_BITS-2:0]   out,
  output logic [N_BITS-1:0]      level,
  output logic                   busy,
  output logic                   done
);

  localparam int THERM_W = 2**N_BITS - 1;

  // The step is held in N_BITS+1 bits so it compares cleanly with |diff|.
  localparam logic [N_BITS:0]   STEP_W = (N_BITS+1)'(MAX_STEP);
  localparam logic [N_BITS-1:0] STEP_N = N_BITS'(MAX_STEP);

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [N_BITS-1:0]    target_q, target_d;
  logic [N_BITS-1:0]    level_q, level_d;
  logic [THERM_W-1:0]   out_q, out_d;
  logic                 done_q, done_d;

  logic                 xfer;
  logic signed [N_BITS:0] diff;
  logic [N_BITS:0]      abs_diff;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: registers update with non-blocking assignments only. All *_q values
  // therefore change together at the edge, and the comb logic never sees a
  // half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      level_q  <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      level_q  <= level_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block. No path can
  // leave one unassigned, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    level_d  = level_q;
    done_d   = 1'b0;

    xfer     = in_valid && in_ready;

    // The distance is taken in N_BITS+1 signed bits, so sign and magnitude
    // are both exact over the full 0 .. 2**N_BITS-1 range.
    diff     = $signed({1'b0, target_q}) - $signed({1'b0, level_q});
    abs_diff = diff[N_BITS] ? N_BITS'(0) - unsigned'(diff) : unsigned'(diff);

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          target_d = in;
          if (in != level_q) begin
            state_d = SLEW;
          end else begin
            // Already there: acknowledge at once with a done pulse.
            done_d = 1'b1;
          end
        end
      end

      SLEW: begin
        // Snap to the target when it is within one step. Otherwise take a
        // full step. A full step is only taken when |diff| > MAX_STEP, so the
        // level can never leave the code range.
        if (abs_diff <= STEP_W) begin
          level_d = target_q;
        end else if (diff[N_BITS]) begin
          level_d = level_q - STEP_N;
        end else begin
          level_d = level_q + STEP_N;
        end

`ifdef BIN2THERM_RETARGET_EN
        // A new target replaces the old one on this edge. This edge's step
        // was already computed against the old target above.
        if (xfer) begin
          target_d = in;
        end
`endif

        // The slew finishes only on reaching the most recent target.
        if (level_d == target_d) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The thermometer code is derived from level_d and registered on the same
  // edge, so 'out' and 'level' can never disagree.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < THERM_W; i++) begin
      out_d[i] = (i < int'(level_d));
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef BIN2THERM_RETARGET_EN
    in_ready = 1'b1;
`else
    in_ready = (state_q == IDLE);
`endif
    busy = (state_q == SLEW);
  end

  assign out   = out_q;
  assign level = level_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bin2therm_slew.sv
// -----------------------------------------------------------------------------
// tb_bin2therm_slew
//
// Directed bench for bin2therm_slew with N_BITS=5. One instance uses
// MAX_STEP=1 (u_dut1) and the other uses MAX_STEP=4 (u_dut4). Both share the
// clock and reset. Expected values are hand-computed constants. When the
// bench is built with BIN2THERM_RETARGET_EN, the ignore-during-slew step is
// replaced by the retarget step.
// -----------------------------------------------------------------------------
module tb_bin2therm_slew;

  logic clk = 1'b0;
  logic rst;

  logic        v1, rdy1, busy1, done1;
  logic [4:0]  in1, lvl1;
  logic [30:0] out1;

  logic        v4, rdy4, busy4, done4;
  logic [4:0]  in4, lvl4;
  logic [30:0] out4;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef BIN2THERM_RETARGET_EN
  localparam int RDY_SLEW = 1;
`else
  localparam int RDY_SLEW = 0;
`endif

  always #5 clk = ~clk;

  bin2therm_slew #(.N_BITS(5), .MAX_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in(in1),
    .out(out1), .level(lvl1), .busy(busy1), .done(done1)
  );

  bin2therm_slew #(.N_BITS(5), .MAX_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in(in4),
    .out(out4), .level(lvl4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned therm(input int l);
    return (l == 0) ? 0 : (32'hFFFF_FFFF >> (32 - l));
  endfunction

  int unsigned prev;

  initial begin
    rst = 1'b1;
    v1 = 1'b1; in1 = 5'd9;   // in_valid must be ignored while in reset
    v4 = 1'b0; in4 = 5'd0;

    // ---- 1. reset state -----------------------------------------------------
    tick(); tick();
    check("rst_out",   32'(out1), 0);
    check("rst_level", 32'(lvl1), 0);
    check("rst_busy",  32'(busy1), 0);
    check("rst_done",  32'(done1), 0);
    check("rst_ready", 32'(rdy1), 1);
    check("rst_level4", 32'(lvl4), 0);
    rst = 1'b0; v1 = 1'b0;
    tick();
    check("post_rst_level", 32'(lvl1), 0);

    // ---- 2. 0 -> 5 at MAX_STEP=1 -------------------------------------------
    in1 = 5'd5; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check("t2_xfer_level", 32'(lvl1), 0);
    check("t2_xfer_busy",  32'(busy1), 1);
    check("t2_xfer_ready", 32'(rdy1), RDY_SLEW);
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("t2_level_%0d", e), 32'(lvl1), e);
      check($sformatf("t2_out_%0d", e),   32'(out1), therm(e));
      check($sformatf("t2_done_%0d", e),  32'(done1), (e == 5) ? 1 : 0);
      check($sformatf("t2_ready_%0d", e), 32'(rdy1), (e == 5) ? 1 : RDY_SLEW);
    end
    check("t2_out_final", 32'(out1), 'h1F);
    tick();
    check("t2_done_clear", 32'(done1), 0);

    // ---- 4. move to 7, then in==level ---------------------------------------
    in1 = 5'd7; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick(); tick();
    check("t4_at7_level", 32'(lvl1), 7);
    check("t4_at7_done",  32'(done1), 1);
    in1 = 5'd7; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check("t4_same_done",  32'(done1), 1);
    check("t4_same_busy",  32'(busy1), 0);
    check("t4_same_ready", 32'(rdy1), 1);
    check("t4_same_out",   32'(out1), 'h7F);
    tick();
    check("t4_done_clear", 32'(done1), 0);
    check("t4_out_hold",   32'(out1), 'h7F);

    // ---- 3. MAX_STEP=4: 0 -> 31, then 31 -> 2 -------------------------------
    in4 = 5'd31; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    check("t3_up_busy", 32'(busy4), 1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("t3_up_level_%0d", e), 32'(lvl4), (4*e > 31) ? 31 : 4*e);
      check($sformatf("t3_up_done_%0d", e),  32'(done4), (e == 8) ? 1 : 0);
    end
    check("t3_up_out", 32'(out4), 'h7FFF_FFFF);
    in4 = 5'd2; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    check("t3_dn_xfer_level", 32'(lvl4), 31);
    prev = 32'(out4);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("t3_dn_level_%0d", e), 32'(lvl4), (31 - 4*e < 2) ? 2 : 31 - 4*e);
      check($sformatf("t3_dn_out_%0d", e),   32'(out4), therm((31 - 4*e < 2) ? 2 : 31 - 4*e));
      check($sformatf("t3_dn_mono_%0d", e),  32'(out4) & ~prev, 0);
      prev = 32'(out4);
    end
    check("t3_dn_done", 32'(done4), 1);

    // ---- reset both, then boundary cases ------------------------------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_level1", 32'(lvl1), 0);
    check("rst2_level4", 32'(lvl4), 0);
    in1 = 5'd0; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check("bnd0_done", 32'(done1), 1);
    check("bnd0_busy", 32'(busy1), 0);
    check("bnd0_out",  32'(out1), 0);

    in4 = 5'd31; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    for (int e = 1; e <= 8; e++) tick();
    check("bndfs_level", 32'(lvl4), 31);
    in4 = 5'd31; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    check("bndfs_done", 32'(done4), 1);
    check("bndfs_busy", 32'(busy4), 0);
    check("bndfs_out",  32'(out4), 'h7FFF_FFFF);

    // ---- 5. reset mid-slew --------------------------------------------------
    in1 = 5'd20; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    check("t5_pre_rst_level", 32'(lvl1), 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_level", 32'(lvl1), 0);
    check("t5_rst_out",   32'(out1), 0);
    check("t5_rst_busy",  32'(busy1), 0);
    check("t5_rst_done",  32'(done1), 0);
    check("t5_rst_ready", 32'(rdy1), 1);
    tick();
    check("t5_no_done", 32'(done1), 0);
    check("t5_still0",  32'(lvl1), 0);

    // ---- 5b / 6. input offered mid-slew at level 10 -------------------------
    in1 = 5'd20; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    check("mid_level10", 32'(lvl1), 10);
    in1 = 5'd4; v1 = 1'b1;
`ifndef BIN2THERM_RETARGET_EN
    in1 = 5'd3;
`endif
    tick();
    v1 = 1'b0;
    check("mid_step_level", 32'(lvl1), 11);
    check("mid_step_busy",  32'(busy1), 1);
    check("mid_step_done",  32'(done1), 0);
`ifdef BIN2THERM_RETARGET_EN
    for (int e = 10; e >= 4; e--) begin
      tick();
      check($sformatf("t6_level_%0d", e), 32'(lvl1), e);
      check($sformatf("t6_done_%0d", e),  32'(done1), (e == 4) ? 1 : 0);
    end
    check("t6_out", 32'(out1), 'hF);
`else
    for (int e = 12; e <= 20; e++) begin
      tick();
      check($sformatf("t5_ign_level_%0d", e), 32'(lvl1), e);
      check($sformatf("t5_ign_done_%0d", e),  32'(done1), (e == 20) ? 1 : 0);
    end
    check("t5_ign_out", 32'(out1), 'hF_FFFF);
`endif
    tick();
    check("final_done_clear", 32'(done1), 0);
    check("final_ready",      32'(rdy1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
